wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage directly upstream of the register file. It drives the register file's write-enable, write-address and write-data inputs. It merges two result sources:
- single-cycle ALU results, through a valid/ready handshake;
- load responses from data memory, which are always accepted and have priority.

Load data is aligned and sign- or zero-extended here. ALU results that lose arbitration wait in a small in-order FIFO.

Parameters:
ALU_FIFO_DEPTH, 2, ALU result FIFO entries (power of 2, >=2)
XLEN, 32, datapath width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
ld_valid  in  1  load response present; always accepted
ld_rd  in  5  load destination register
ld_rdata  in  XLEN  raw aligned memory word
ld_offset  in  2  byte address [1:0]
ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU)
reg_write  out  1  register file write enable
wb_rd  out  5  register file write address
w_data  out  XLEN  register file write data
fifo_count  out  clog2(DEPTH)+1  ALU FIFO occupancy

Behaviour:
- Reset: asynchronous, active-high. Clock port is clk; reset port is rst, asserted asynchronously, active-high.
- Reset values: reg_write=0, wb_rd=0, w_data=0, fifo_count=0, FIFO emptied.
- Reset mid-operation: discards FIFO contents and any pending writeback. Outputs return to reset values immediately, not at the next edge.
- Outputs reg_write, wb_rd and w_data are registered. Latency is 1 cycle from the selecting edge.
- Arbitration each cycle, priority high to low:
  (1) ld_valid: write back the load result.
  (2) FIFO not empty: pop the head and write it back.
  (3) alu_valid and FIFO empty: bypass the ALU result directly to the output registers.
  (4) Otherwise reg_write=0 next cycle.
- Accepted ALU results not selected in the same cycle are pushed to the FIFO tail.
- Simultaneous push and pop is legal; count is unchanged. Order is strictly in-order.
- alu_ready = (fifo_count < ALU_FIFO_DEPTH). It is a function of registered state only, with no combinational path from ld_valid or alu_valid.
- When full, a pop in the same cycle does not raise alu_ready until the next cycle.
- Continuous ld_valid starves the FIFO. This is permitted; upstream bounds load rate.
- rd==0 from either source:
  - the entry is consumed and arbitration proceeds normally;
  - reg_write=0 that cycle, wb_rd=0, w_data holds its previous value.
- Load extension:
  - LB/LBU select byte ld_offset[1:0].
  - LH/LHU select halfword ld_offset[1] and ignore ld_offset[0].
  - LW ignores the offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Reserved funct3 values (011, 110, 111) are treated as LW.
- wb_rd/w_data hold their values when reg_write=0, except in the rd==0 case above.
- Upstream owns WAW ordering between load and ALU results to the same rd. This block does not reorder against it.

Optional Feature:
WB_FWD_EN
- Defined: adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (XLEN). They combinationally present the selection being registered this cycle, for operand bypass.
  - fwd_valid = a write with rd!=0 is being selected.
  - fwd_valid=0 during reset.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package wb_pkg:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101;
  - typedef alu_entry_t {rd[4:0], data[XLEN-1:0]};
  - function load_extend(rdata, offset, funct3).
- One sub-module, wb_fifo: synchronous-write FIFO with count output and async reset, parameterised by depth and entry width.

Test Plan:
- Reset release, then alu_valid, rd=5, data=0x1234 → next cycle reg_write=1, wb_rd=5, w_data=0x00001234; fifo_count stays 0.
- ld_valid (rd=3, LB, offset=2, rdata=0x00800000) with alu_valid (rd=4, 0xAA) the same cycle → cycle+1: rd=3, w_data=0xFFFFFF80. Cycle+2: rd=4, w_data=0xAA.
- ld_valid held 3 cycles with alu_valid every cycle → FIFO fills to 2 and alu_ready=0. After loads stop, the ALU results drain in order; no loss or duplication.
- LHU, offset=3, rdata=0xBEEF1234 → w_data=0x0000BEEF. LH, offset=0 → 0x00001234. funct3=111 → 0xBEEF1234.
- ALU rd=0 with data 0xFFFFFFFF → reg_write stays 0; the transaction is consumed (alu_ready unaffected afterwards).
- rst asserted mid-drain with fifo_count=2 → outputs and fifo_count go to 0 asynchronously; no writes after release.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared load-type encodings, ALU entry type and load alignment/extension helper
package wb_pkg;
  localparam int WB_XLEN = 32;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } alu_entry_t;
  // Reserved funct3 encodings fall through to the full-word path.
  function automatic logic [WB_XLEN-1:0] load_extend(input logic [WB_XLEN-1:0] rdata,
                                                      input logic [1:0] offset,
                                                      input logic [2:0] funct3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {offset, 3'b000});
    h = 16'(rdata >> {offset[1], 4'b0000});
    case (funct3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LBU:  return {24'd0, b};
      F3_LHU:  return {16'd0, h};
      default: return rdata;
    endcase
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order FIFO with occupancy count and async active-high reset
//   clk, rst          clock / async reset (pointers and count only)
//   i_push, i_data    write an entry at the tail
//   i_pop             remove the head (caller guarantees non-empty)
//   o_data            head entry
//   o_count           occupancy, 0..DEPTH
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk) if (i_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback arbiter merging load responses (priority) and ALU results into the register file
//   clk, rst                       clock / async active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   ld_valid/ld_rd/ld_rdata/ld_offset/ld_funct3   load response, always accepted
//   reg_write/wb_rd/w_data         registered register-file write port
//   fifo_count                     ALU FIFO occupancy
//   WB_FWD_EN: adds fwd_valid/fwd_rd/fwd_data, the selection being registered this cycle
module wb_stage
  import wb_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int XLEN           = WB_XLEN
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [4:0]                        alu_rd,
  input  logic [XLEN-1:0]                   alu_data,
  input  logic                              ld_valid,
  input  logic [4:0]                        ld_rd,
  input  logic [XLEN-1:0]                   ld_rdata,
  input  logic [1:0]                        ld_offset,
  input  logic [2:0]                        ld_funct3,
  output logic                              reg_write,
  output logic [4:0]                        wb_rd,
  output logic [XLEN-1:0]                   w_data,
  output logic [$clog2(ALU_FIFO_DEPTH):0]   fifo_count
`ifdef WB_FWD_EN
  ,
  output logic                              fwd_valid,
  output logic [4:0]                        fwd_rd,
  output logic [XLEN-1:0]                   fwd_data
`endif
);
  localparam int CW = $clog2(ALU_FIFO_DEPTH) + 1;
  localparam int EW = 5 + XLEN;
  logic            w_empty, w_accept, w_pop, w_bypass, w_push, w_sel, w_we;
  logic [EW-1:0]   w_head;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_ld_data, w_sel_data;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  // Ready depends only on registered occupancy, so a pop while full frees a slot one cycle later.
  assign alu_ready = fifo_count < CW'(ALU_FIFO_DEPTH);
  assign w_empty   = fifo_count == '0;
  assign w_accept  = alu_valid && alu_ready;
  assign w_pop     = !ld_valid && !w_empty;
  assign w_bypass  = !ld_valid && w_empty && w_accept;
  assign w_push    = w_accept && !w_bypass;
  assign w_sel     = ld_valid || !w_empty || w_accept;
  // Sign-extending the 32-bit result is also correct for wider XLEN (LBU/LHU keep bit 31 clear).
  assign w_ld_data  = XLEN'($signed(load_extend(ld_rdata[WB_XLEN-1:0], ld_offset, ld_funct3)));
  assign w_rd       = ld_valid ? ld_rd : !w_empty ? w_head[EW-1:XLEN] : alu_rd;
  assign w_sel_data = ld_valid ? w_ld_data : !w_empty ? w_head[XLEN-1:0] : alu_data;
  assign w_we       = w_sel && w_rd != 5'd0;
  wb_fifo #(.DEPTH(ALU_FIFO_DEPTH), .W(EW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({alu_rd, alu_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (fifo_count)
  );
  // A consumed rd==0 entry clears wb_rd but leaves w_data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we   <= w_we;
      r_rd   <= w_we ? w_rd : w_sel ? 5'd0 : r_rd;
      r_data <= w_we ? w_sel_data : r_data;
    end
  end
  assign reg_write = r_we;
  assign wb_rd     = r_rd;
  assign w_data    = r_data;
`ifdef WB_FWD_EN
  assign fwd_valid = w_we && !rst;
  assign fwd_rd    = w_rd;
  assign fwd_data  = w_sel_data;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard and vector-table bench for wb_stage
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        ld_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] alu_data = '0;
  logic [31:0] ld_rdata = '0;
  logic [1:0]  ld_offset = '0;
  logic [2:0]  ld_funct3 = '0;
  logic        alu_ready, reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] w_data;
  logic [1:0]  fifo_count;
  int total = 0;
  int bad = 0;
  typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
  typedef struct {logic we; logic [4:0] rd; logic [31:0] d; int cnt;} exp_t;
  typedef struct {logic [2:0] f3; logic [1:0] off; logic [31:0] raw; logic [31:0] exp;} vec_t;
  ent_t mq[$];
  exp_t eq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_d = '0;

  wb_stage #(.ALU_FIFO_DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_rdata(ld_rdata), .ld_offset(ld_offset), .ld_funct3(ld_funct3),
    .reg_write(reg_write), .wb_rd(wb_rd), .w_data(w_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  // Drive one cycle; the expected writeback is queued now and compared after the edge.
  // lexp is the independently worked-out extended load value.
  task automatic cycle(input logic lv, input logic [4:0] lrd, input logic [31:0] lraw,
                       input logic [1:0] off, input logic [2:0] f3, input logic [31:0] lexp,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       output logic acc);
    logic byp, sv;
    ent_t s;
    exp_t e;
    ld_valid = lv; ld_rd = lrd; ld_rdata = lraw; ld_offset = off; ld_funct3 = f3;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, mq.size() < 2});
    acc = av && mq.size() < 2;
    byp = !lv && mq.size() == 0 && acc;
    sv = 1'b1;
    s = '{5'd0, 32'd0};
    if (lv) s = '{lrd, lexp};
    else if (mq.size() != 0) s = mq.pop_front();
    else if (acc) s = '{ard, ad};
    else sv = 1'b0;
    if (acc && !byp) mq.push_back('{ard, ad});
    if (sv && s.rd != 5'd0) begin
      m_we = 1'b1; m_rd = s.rd; m_d = s.d;
    end else begin
      m_we = 1'b0;
      if (sv) m_rd = 5'd0;
    end
    eq.push_back('{m_we, m_rd, m_d, mq.size()});
    @(posedge clk);
    #1;
    e = eq.pop_front();
    chk("reg_write", {31'd0, reg_write}, {31'd0, e.we});
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
    chk("w_data", w_data, e.d);
    chk("fifo_count", {30'd0, fifo_count}, 32'(e.cnt));
  endtask

  task automatic idle();
    logic a;
    cycle(1'b0, 5'd0, 32'd0, 2'd0, 3'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    logic a;
    cycle(1'b0, 5'd0, 32'd0, 2'd0, 3'd0, 32'd0, 1'b1, rd, d, a);
  endtask

  task automatic ld_lw(input logic [4:0] rd, input logic [31:0] raw, input logic av,
                       input logic [4:0] ard, input logic [31:0] ad);
    logic a;
    cycle(1'b1, rd, raw, 2'd0, 3'b010, raw, av, ard, ad, a);
  endtask

  initial begin
    vec_t vt[15];
    logic a, lv, pend;
    logic [4:0] prd;
    logic [31:0] pd, raw;
    vt[0]  = '{3'b101, 2'd3, 32'hBEEF1234, 32'h0000BEEF};
    vt[1]  = '{3'b001, 2'd0, 32'hBEEF1234, 32'h00001234};
    vt[2]  = '{3'b111, 2'd1, 32'hBEEF1234, 32'hBEEF1234};
    vt[3]  = '{3'b000, 2'd0, 32'h80FF7F01, 32'h00000001};
    vt[4]  = '{3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F};
    vt[5]  = '{3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
    vt[6]  = '{3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    vt[7]  = '{3'b100, 2'd3, 32'h80FF7F01, 32'h00000080};
    vt[8]  = '{3'b100, 2'd2, 32'h80FF7F01, 32'h000000FF};
    vt[9]  = '{3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};
    vt[10] = '{3'b101, 2'd1, 32'h80FF7F01, 32'h00007F01};
    vt[11] = '{3'b010, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
    vt[12] = '{3'b011, 2'd1, 32'h12345678, 32'h12345678};
    vt[13] = '{3'b110, 2'd2, 32'hCAFEF00D, 32'hCAFEF00D};
    vt[14] = '{3'b001, 2'd1, 32'h00008001, 32'hFFFF8001};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_fifo_count", {30'd0, fifo_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    alu(5'd5, 32'h1234);
    cycle(1'b1, 5'd3, 32'h00800000, 2'd2, 3'b000, 32'hFFFFFF80, 1'b1, 5'd4, 32'hAA, a);
    idle();
    idle();

    ld_lw(5'd6, 32'h11111111, 1'b1, 5'd7, 32'hA1);
    ld_lw(5'd8, 32'h22222222, 1'b1, 5'd9, 32'hA2);
    ld_lw(5'd10, 32'h33333333, 1'b1, 5'd11, 32'hA3);
    alu(5'd11, 32'hA3);
    alu(5'd11, 32'hA3);
    idle();
    idle();

    for (int i = 0; i < 15; i++)
      cycle(1'b1, 5'(i + 1), vt[i].raw, vt[i].off, vt[i].f3, vt[i].exp, 1'b0, 5'd0, 32'd0, a);

    alu(5'd0, 32'hFFFFFFFF);
    idle();
    alu(5'd12, 32'h5);
    cycle(1'b1, 5'd0, 32'h77, 2'd0, 3'b010, 32'h77, 1'b1, 5'd13, 32'h99, a);
    idle();
    idle();

    ld_lw(5'd13, 32'h1, 1'b1, 5'd14, 32'hB1);
    ld_lw(5'd15, 32'h2, 1'b1, 5'd16, 32'hB2);
    ld_valid = 1'b0;
    alu_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("arst_w_data", w_data, 32'd0);
    chk("arst_fifo_count", {30'd0, fifo_count}, 32'd0);
    chk("arst_alu_ready", {31'd0, alu_ready}, 32'd1);
    mq.delete();
    m_we = 1'b0; m_rd = '0; m_d = '0;
    @(negedge clk);
    rst = 1'b0;
    idle();
    idle();
    idle();

    pend = 1'b0;
    prd = '0;
    pd = '0;
    for (int i = 0; i < 200; i++) begin
      lv = $urandom_range(0, 2) == 0;
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        prd = 5'($urandom);
        pd = $urandom;
      end
      raw = $urandom;
      cycle(lv, 5'($urandom), raw, 2'($urandom), 3'b010, raw, pend, prd, pd, a);
      if (a) pend = 1'b0;
    end
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
